// File: rtl/io16_pkg.sv
// Shared constants for the IO16 SPI target: register map, ID value and FSM states.
package io16_pkg;

  localparam logic [7:0] ID_VALUE_DEFAULT = 8'hA5;

  localparam logic [6:0] ADDR_IN_L   = 7'h00;
  localparam logic [6:0] ADDR_IN_H   = 7'h01;
  localparam logic [6:0] ADDR_OUT_L  = 7'h02;
  localparam logic [6:0] ADDR_OUT_H  = 7'h03;
  localparam logic [6:0] ADDR_DIR_L  = 7'h04;
  localparam logic [6:0] ADDR_DIR_H  = 7'h05;
  localparam logic [6:0] ADDR_MASK_L = 7'h06;
  localparam logic [6:0] ADDR_MASK_H = 7'h07;
  localparam logic [6:0] ADDR_FLAG_L = 7'h08;
  localparam logic [6:0] ADDR_FLAG_H = 7'h09;
  localparam logic [6:0] ADDR_ID     = 7'h0F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

endpackage

// File: rtl/io16_spi_target_if.sv
// SPI link between the carrier CPLD (master side) and the IO16 card (slave side).
interface io16_spi_if;
  logic spi_nss;
  logic spi_clk;
  logic spi_mosi;
  logic spi_miso;
  logic spi_int;

  modport master (output spi_nss, spi_clk, spi_mosi, input spi_miso, spi_int);
  modport slave  (input spi_nss, spi_clk, spi_mosi, output spi_miso, spi_int);
endinterface

// File: rtl/io16_spi_target_shifter.sv
// Oversampling SPI mode-0 front end: synchronisers, edge detect, bit counter, rx/tx shifters.
module io16_spi_shifter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_nss,
  input  logic       i_sclk,
  input  logic       i_mosi,
  input  logic [7:0] i_tx_data,
  output logic       o_cs_active,
  output logic       o_cs_fall,
  output logic       o_byte_valid,
  output logic       o_tx_load,
  output logic [7:0] o_rx_byte,
  output logic       o_tx_bit
);

  logic [1:0] r_nss_sync;
  logic [1:0] r_sclk_sync;
  logic [1:0] r_mosi_sync;
  logic       r_nss_prev;
  logic       r_sclk_prev;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_rx;
  logic [7:0] r_tx;

  logic w_nss;
  logic w_sclk;
  logic w_mosi;
  logic w_rise;
  logic w_fall;

  assign w_nss  = r_nss_sync[1];
  assign w_sclk = r_sclk_sync[1];
  assign w_mosi = r_mosi_sync[1];
  assign w_rise = w_sclk & ~r_sclk_prev & ~w_nss;
  assign w_fall = ~w_sclk & r_sclk_prev & ~w_nss;

  assign o_cs_active  = ~w_nss;
  assign o_cs_fall    = ~w_nss & r_nss_prev;
  assign o_byte_valid = w_rise && (r_bit_cnt == 3'd7);
  assign o_tx_load    = o_byte_valid;
  assign o_rx_byte    = {r_rx, w_mosi};
  assign o_tx_bit     = r_tx[7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nss_sync  <= 2'b11;
      r_sclk_sync <= 2'b00;
      r_mosi_sync <= 2'b00;
      r_nss_prev  <= 1'b1;
      r_sclk_prev <= 1'b0;
    end else begin
      r_nss_sync  <= {r_nss_sync[0], i_nss};
      r_sclk_sync <= {r_sclk_sync[0], i_sclk};
      r_mosi_sync <= {r_mosi_sync[0], i_mosi};
      r_nss_prev  <= w_nss;
      r_sclk_prev <= w_sclk;
    end
  end

  // The falling edge right after a load (bit count 0) must not shift: the
  // master has not yet sampled the freshly presented MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= 3'd0;
      r_rx      <= 7'd0;
      r_tx      <= 8'd0;
    end else if (w_nss) begin
      r_bit_cnt <= 3'd0;
      r_rx      <= 7'd0;
      r_tx      <= 8'd0;
    end else begin
      if (w_rise) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
        r_rx      <= {r_rx[5:0], w_mosi};
      end
      if (o_tx_load) begin
        r_tx <= i_tx_data;
      end else if (w_fall && (r_bit_cnt != 3'd0)) begin
        r_tx <= {r_tx[6:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/io16_spi_target.sv
// IO16 card SPI target: frame FSM, auto-incrementing address, GPIO register file and
// change interrupts.  States: IDLE = no frame | CMD = receiving command byte | DATA = data bytes.
module io16_spi_target
  import io16_pkg::*;
#(
  parameter int         NUM_IO   = 16,
  parameter logic [7:0] ID_VALUE = ID_VALUE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  io16_spi_if.slave         spi,
  input  logic [NUM_IO-1:0] i_gpio_in,
  output logic [NUM_IO-1:0] o_gpio_out,
  output logic [NUM_IO-1:0] o_gpio_oe
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_read;
  logic [6:0]        r_addr;
  logic [NUM_IO-1:0] r_gpio_meta;
  logic [NUM_IO-1:0] r_gpio_sync;
  logic [NUM_IO-1:0] r_gpio_prev;
  logic [NUM_IO-1:0] r_out;
  logic [NUM_IO-1:0] r_dir;
  logic [NUM_IO-1:0] r_mask;
  logic [NUM_IO-1:0] r_flag;

  logic              w_cs_active;
  logic              w_cs_fall;
  logic              w_byte_valid;
  logic              w_tx_load;
  logic [7:0]        w_rx_byte;
  logic              w_tx_bit;
  logic [6:0]        w_tx_addr;
  logic [7:0]        w_tx_data;
  logic              w_wr;
  logic [NUM_IO-1:0] w_w1c;
  logic [NUM_IO-1:0] w_set;

  io16_spi_shifter u_shifter (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_nss        (spi.spi_nss),
    .i_sclk       (spi.spi_clk),
    .i_mosi       (spi.spi_mosi),
    .i_tx_data    (w_tx_data),
    .o_cs_active  (w_cs_active),
    .o_cs_fall    (w_cs_fall),
    .o_byte_valid (w_byte_valid),
    .o_tx_load    (w_tx_load),
    .o_rx_byte    (w_rx_byte),
    .o_tx_bit     (w_tx_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!w_cs_active) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_cs_fall)    w_state_nxt = ST_CMD;
        ST_CMD:  if (w_byte_valid) w_state_nxt = ST_DATA;
        ST_DATA: w_state_nxt = ST_DATA;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_read <= 1'b0;
      r_addr <= 7'd0;
    end else if (r_state == ST_CMD && w_byte_valid) begin
      r_read <= w_rx_byte[7];
      r_addr <= w_rx_byte[6:0];
    end else if (r_state == ST_DATA && w_tx_load) begin
      r_addr <= r_addr + 7'd1;
    end
  end

  // Next byte to transmit: the command's start address, else the following address.
  assign w_tx_addr = (r_state == ST_CMD) ? w_rx_byte[6:0] : (r_addr + 7'd1);

  always_comb begin
    w_tx_data = 8'h00;
    case (w_tx_addr)
      ADDR_IN_L:   w_tx_data = r_gpio_sync[7:0];
      ADDR_IN_H:   w_tx_data = r_gpio_sync[15:8];
      ADDR_OUT_L:  w_tx_data = r_out[7:0];
      ADDR_OUT_H:  w_tx_data = r_out[15:8];
      ADDR_DIR_L:  w_tx_data = r_dir[7:0];
      ADDR_DIR_H:  w_tx_data = r_dir[15:8];
      ADDR_MASK_L: w_tx_data = r_mask[7:0];
      ADDR_MASK_H: w_tx_data = r_mask[15:8];
      ADDR_FLAG_L: w_tx_data = r_flag[7:0];
      ADDR_FLAG_H: w_tx_data = r_flag[15:8];
      ADDR_ID:     w_tx_data = ID_VALUE;
      default:     w_tx_data = 8'h00;
    endcase
  end

  assign w_wr = (r_state == ST_DATA) && w_byte_valid && !r_read;

  always_comb begin
    w_w1c = '0;
    if (w_wr && r_addr == ADDR_FLAG_L) w_w1c[7:0]  = w_rx_byte;
    if (w_wr && r_addr == ADDR_FLAG_H) w_w1c[15:8] = w_rx_byte;
  end

  assign w_set = (r_gpio_sync ^ r_gpio_prev) & r_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gpio_meta <= '0;
      r_gpio_sync <= '0;
      r_gpio_prev <= '0;
    end else begin
      r_gpio_meta <= i_gpio_in;
      r_gpio_sync <= r_gpio_meta;
      r_gpio_prev <= r_gpio_sync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out  <= '0;
      r_dir  <= '0;
      r_mask <= '0;
      r_flag <= '0;
    end else begin
      if (w_wr) begin
        case (r_addr)
          ADDR_OUT_L:  r_out[7:0]   <= w_rx_byte;
          ADDR_OUT_H:  r_out[15:8]  <= w_rx_byte;
          ADDR_DIR_L:  r_dir[7:0]   <= w_rx_byte;
          ADDR_DIR_H:  r_dir[15:8]  <= w_rx_byte;
          ADDR_MASK_L: r_mask[7:0]  <= w_rx_byte;
          ADDR_MASK_H: r_mask[15:8] <= w_rx_byte;
          default: ;
        endcase
      end
      // A new change event outranks a simultaneous clear.
      r_flag <= (r_flag & ~w_w1c) | w_set;
    end
  end

  assign o_gpio_out   = r_out;
  assign o_gpio_oe    = r_dir;
  assign spi.spi_int  = |r_flag;
  assign spi.spi_miso = w_tx_bit & r_read & (r_state == ST_DATA);

endmodule

// File: tb/tb_io16_spi_target.sv
// Bit-banged SPI master driving io16_spi_target, checked against a register-map model.
module tb_io16_spi_target;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] gpio_in = 16'h0000;
  logic [15:0] gpio_out;
  logic [15:0] gpio_oe;

  io16_spi_if spi_bus ();

  io16_spi_target dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi        (spi_bus.slave),
    .i_gpio_in  (gpio_in),
    .o_gpio_out (gpio_out),
    .o_gpio_oe  (gpio_oe)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [15:0] m_pins = 16'h0000;
  logic [15:0] m_out = 16'h0000;
  logic [15:0] m_dir = 16'h0000;
  logic [15:0] m_mask = 16'h0000;
  logic [15:0] m_flag = 16'h0000;

  function automatic logic [7:0] model_read(input logic [6:0] a);
    case (a)
      7'h00: return m_pins[7:0];
      7'h01: return m_pins[15:8];
      7'h02: return m_out[7:0];
      7'h03: return m_out[15:8];
      7'h04: return m_dir[7:0];
      7'h05: return m_dir[15:8];
      7'h06: return m_mask[7:0];
      7'h07: return m_mask[15:8];
      7'h08: return m_flag[7:0];
      7'h09: return m_flag[15:8];
      7'h0F: return 8'hA5;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_write(input logic [6:0] a, input logic [7:0] d);
    case (a)
      7'h02: m_out[7:0]   = d;
      7'h03: m_out[15:8]  = d;
      7'h04: m_dir[7:0]   = d;
      7'h05: m_dir[15:8]  = d;
      7'h06: m_mask[7:0]  = d;
      7'h07: m_mask[15:8] = d;
      7'h08: m_flag[7:0]  = m_flag[7:0] & ~d;
      7'h09: m_flag[15:8] = m_flag[15:8] & ~d;
      default: ;
    endcase
  endtask

  task automatic set_pins(input logic [15:0] v);
    m_flag  = m_flag | ((m_pins ^ v) & m_mask);
    m_pins  = v;
    gpio_in = v;
    #200;
  endtask

  task automatic spi_begin();
    spi_bus.spi_nss = 1'b0;
    #80;
  endtask

  task automatic spi_end();
    #80;
    spi_bus.spi_nss = 1'b1;
    #160;
  endtask

  // Shifts nbits of d MSB first; toggle is applied to gpio_in at the last rising edge.
  task automatic spi_byte(input logic [7:0] d, input int nbits, input logic [15:0] toggle,
                          output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_bus.spi_mosi = d[7-i];
      #80;
      rx[7-i] = spi_bus.spi_miso;
      spi_bus.spi_clk = 1'b1;
      if (i == nbits - 1) gpio_in = gpio_in ^ toggle;
      #80;
      spi_bus.spi_clk = 1'b0;
    end
  endtask

  task automatic spi_write(input logic [6:0] a, input logic [7:0] data[$], output logic miso_seen);
    logic [7:0] rx;
    logic [6:0] addr;
    addr = a;
    spi_begin();
    spi_byte({1'b0, a}, 8, 16'h0, rx);
    miso_seen = (rx != 8'h00);
    foreach (data[k]) begin
      spi_byte(data[k], 8, 16'h0, rx);
      miso_seen = miso_seen | (rx != 8'h00);
      model_write(addr, data[k]);
      addr = addr + 7'd1;
    end
    spi_end();
  endtask

  task automatic spi_read(input logic [6:0] a, input int n, output logic [7:0] got[$]);
    logic [7:0] rx;
    got = {};
    spi_begin();
    spi_byte({1'b1, a}, 8, 16'h0, rx);
    for (int k = 0; k < n; k++) begin
      spi_byte(8'($urandom), 8, 16'h0, rx);
      got.push_back(rx);
    end
    spi_end();
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #20;
    total++; if (gpio_out !== 16'h0000) begin bad++; $display("FAIL rst_gpio_out got=%h want=0000", gpio_out); end
    total++; if (gpio_oe !== 16'h0000) begin bad++; $display("FAIL rst_gpio_oe got=%h want=0000", gpio_oe); end
    total++; if (spi_bus.spi_miso !== 1'b0) begin bad++; $display("FAIL rst_miso got=%b want=0", spi_bus.spi_miso); end
    total++; if (spi_bus.spi_int !== 1'b0) begin bad++; $display("FAIL rst_int got=%b want=0", spi_bus.spi_int); end
    #29 rst_n = 1'b1;
    #200;
  endtask

  task automatic test_write_read();
    logic       seen;
    logic [7:0] got[$];
    spi_write(7'h02, '{8'h34, 8'h12}, seen);
    total++; if (gpio_out !== 16'h1234) begin bad++; $display("FAIL wr_gpio_out got=%h want=1234", gpio_out); end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL wr_miso_idle got=%b want=0", seen); end
    spi_read(7'h02, 2, got);
    total++; if (got[0] !== 8'h34) begin bad++; $display("FAIL rd_out_l got=%h want=34", got[0]); end
    total++; if (got[1] !== 8'h12) begin bad++; $display("FAIL rd_out_h got=%h want=12", got[1]); end
  endtask

  task automatic test_partial();
    logic [7:0] rx;
    logic       seen;
    spi_begin();
    spi_byte(8'h04, 8, 16'h0, rx);
    spi_byte(8'hFF, 5, 16'h0, rx);
    spi_end();
    total++; if (gpio_oe !== 16'h0000) begin bad++; $display("FAIL partial_oe got=%h want=0000", gpio_oe); end
    spi_write(7'h04, '{8'h0F}, seen);
    total++; if (gpio_oe !== 16'h000F) begin bad++; $display("FAIL after_partial_oe got=%h want=000f", gpio_oe); end
  endtask

  task automatic test_id_wrap();
    logic [7:0] got[$];
    spi_read(7'h0F, 1, got);
    total++; if (got[0] !== 8'hA5) begin bad++; $display("FAIL id got=%h want=a5", got[0]); end
    spi_read(7'h7F, 2, got);
    total++; if (got[0] !== 8'h00) begin bad++; $display("FAIL unmapped_7f got=%h want=00", got[0]); end
    total++; if (got[1] !== model_read(7'h00)) begin bad++; $display("FAIL wrap_in_l got=%h want=%h", got[1], model_read(7'h00)); end
  endtask

  task automatic test_interrupt();
    logic       seen;
    logic [7:0] rx;
    logic [7:0] got[$];
    spi_write(7'h08, '{8'hFF, 8'hFF}, seen);
    spi_write(7'h06, '{8'h01, 8'h00}, seen);
    total++; if (spi_bus.spi_int !== 1'b0) begin bad++; $display("FAIL int_idle got=%b want=0", spi_bus.spi_int); end
    @(posedge clk); #1;
    gpio_in[0] = ~gpio_in[0];
    m_pins[0]  = ~m_pins[0];
    m_flag[0]  = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    total++; if (spi_bus.spi_int !== 1'b0) begin bad++; $display("FAIL int_early got=%b want=0", spi_bus.spi_int); end
    @(posedge clk); #1;
    total++; if (spi_bus.spi_int !== 1'b1) begin bad++; $display("FAIL int_latency got=%b want=1", spi_bus.spi_int); end
    #200;
    // Clear write and second toggle land in the same clock cycle.
    spi_begin();
    spi_byte(8'h08, 8, 16'h0, rx);
    spi_byte(8'h01, 8, 16'h0001, rx);
    spi_end();
    m_pins = m_pins ^ 16'h0001;
    m_flag = (m_flag & ~16'h0001) | (16'h0001 & m_mask);
    total++; if (spi_bus.spi_int !== 1'b1) begin bad++; $display("FAIL collision_set_wins got=%b want=1", spi_bus.spi_int); end
    spi_read(7'h08, 1, got);
    total++; if (got[0] !== model_read(7'h08)) begin bad++; $display("FAIL collision_flag got=%h want=%h", got[0], model_read(7'h08)); end
    spi_write(7'h08, '{8'h01}, seen);
    total++; if (spi_bus.spi_int !== 1'b0) begin bad++; $display("FAIL w1c_clear got=%b want=0", spi_bus.spi_int); end
    set_pins(m_pins ^ 16'h0001);
    spi_write(7'h06, '{8'h00, 8'h00}, seen);
    total++; if (spi_bus.spi_int !== 1'b1) begin bad++; $display("FAIL mask_keeps_flag got=%b want=1", spi_bus.spi_int); end
    spi_write(7'h08, '{8'hFF, 8'hFF}, seen);
    total++; if (spi_bus.spi_int !== 1'b0) begin bad++; $display("FAIL final_clear got=%b want=0", spi_bus.spi_int); end
  endtask

  task automatic test_random();
    logic       seen;
    logic [6:0] a;
    int         n;
    logic [7:0] data[$];
    logic [7:0] exp[$];
    logic [7:0] got[$];
    for (int it = 0; it < 16; it++) begin
      set_pins(16'($urandom));
      a = ($urandom_range(0, 7) == 0) ? 7'h7F : 7'($urandom_range(0, 16));
      n = $urandom_range(1, 4);
      data = {};
      for (int k = 0; k < n; k++) data.push_back(8'($urandom));
      spi_write(a, data, seen);
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL rnd_wr_miso it=%0d got=%b want=0", it, seen); end
      total++; if (gpio_out !== m_out) begin bad++; $display("FAIL rnd_gpio_out it=%0d got=%h want=%h", it, gpio_out, m_out); end
      total++; if (gpio_oe !== m_dir) begin bad++; $display("FAIL rnd_gpio_oe it=%0d got=%h want=%h", it, gpio_oe, m_dir); end
      total++; if (spi_bus.spi_int !== (|m_flag)) begin bad++; $display("FAIL rnd_int it=%0d got=%b want=%b", it, spi_bus.spi_int, |m_flag); end
      a = 7'($urandom_range(0, 16));
      n = $urandom_range(1, 4);
      exp = {};
      for (int k = 0; k < n; k++) exp.push_back(model_read(a + 7'(k)));
      spi_read(a, n, got);
      for (int k = 0; k < n; k++) begin
        total++;
        if (got[k] !== exp[k]) begin
          bad++; $display("FAIL rnd_read it=%0d addr=%h got=%h want=%h", it, a + 7'(k), got[k], exp[k]);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic       seen;
    logic [7:0] rx;
    logic [7:0] got[$];
    spi_write(7'h02, '{8'hAA, 8'h55, 8'hF0, 8'h0F, 8'hFF, 8'hFF}, seen);
    set_pins(m_pins ^ 16'h00FF);
    spi_begin();
    spi_byte(8'h04, 8, 16'h0, rx);
    spi_byte(8'hC3, 4, 16'h0, rx);
    rst_n = 1'b0;
    #1;
    m_out = 16'h0; m_dir = 16'h0; m_mask = 16'h0; m_flag = 16'h0;
    total++; if (gpio_out !== 16'h0000) begin bad++; $display("FAIL midrst_out got=%h want=0000", gpio_out); end
    total++; if (gpio_oe !== 16'h0000) begin bad++; $display("FAIL midrst_oe got=%h want=0000", gpio_oe); end
    total++; if (spi_bus.spi_int !== 1'b0) begin bad++; $display("FAIL midrst_int got=%b want=0", spi_bus.spi_int); end
    total++; if (spi_bus.spi_miso !== 1'b0) begin bad++; $display("FAIL midrst_miso got=%b want=0", spi_bus.spi_miso); end
    #40 rst_n = 1'b1;
    spi_end();
    spi_write(7'h04, '{8'h3C}, seen);
    total++; if (gpio_oe !== 16'h003C) begin bad++; $display("FAIL post_rst_oe got=%h want=003c", gpio_oe); end
    spi_read(7'h02, 2, got);
    total++; if (got[0] !== 8'h00) begin bad++; $display("FAIL post_rst_out_l got=%h want=00", got[0]); end
    total++; if (got[1] !== 8'h00) begin bad++; $display("FAIL post_rst_out_h got=%h want=00", got[1]); end
  endtask

  initial begin
    spi_bus.spi_nss  = 1'b1;
    spi_bus.spi_clk  = 1'b0;
    spi_bus.spi_mosi = 1'b0;
    test_reset();
    test_write_read();
    test_partial();
    test_id_wrap();
    test_interrupt();
    test_random();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
